// File: rtl/cursor_frame_sched_pkg.sv
// Shared definitions for the cursor frame scheduler:
// state encoding, ADC/channel widths, saturating increment.
package boreal_sched_pkg;

  localparam int ADC_W = 24;
  localparam int CH_W  = 3;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONV    = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_SETTLE  = 3'd4,
    S_SEND    = 3'd5
  } sched_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    if (v == {CNT_W{1'b1}})
      return v;
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cursor_frame_sched_if.sv
// Scheduler bus: frame control, ADC handshake, UART
// request and status. master = scheduler, slave = environment.
//   enable, emergency_halt_n, clear_status : control in
//   adc_start/adc_done/adc_data_in         : ADC front end
//   raw_adc_out/adc_channel_sel/adc_data_ready : decoder core
//   uart_busy/send_packet_strobe           : cursor UART
//   frame_overrun/timeout_cnt/sched_state  : status/debug
interface cursor_frame_sched_if;
  import boreal_sched_pkg::*;

  logic             enable;
  logic             emergency_halt_n;
  logic             adc_start;
  logic             adc_done;
  logic [ADC_W-1:0] adc_data_in;
  logic [ADC_W-1:0] raw_adc_out;
  logic [CH_W-1:0]  adc_channel_sel;
  logic             adc_data_ready;
  logic             uart_busy;
  logic             send_packet_strobe;
  logic             clear_status;
  logic             frame_overrun;
  logic [CNT_W-1:0] timeout_cnt;
  logic [2:0]       sched_state;

  modport master (
    input  enable,
    input  emergency_halt_n,
    output adc_start,
    input  adc_done,
    input  adc_data_in,
    output raw_adc_out,
    output adc_channel_sel,
    output adc_data_ready,
    input  uart_busy,
    output send_packet_strobe,
    input  clear_status,
    output frame_overrun,
    output timeout_cnt,
    output sched_state
  );

  modport slave (
    output enable,
    output emergency_halt_n,
    input  adc_start,
    output adc_done,
    output adc_data_in,
    input  raw_adc_out,
    input  adc_channel_sel,
    input  adc_data_ready,
    output uart_busy,
    input  send_packet_strobe,
    output clear_status,
    input  frame_overrun,
    input  timeout_cnt,
    input  sched_state
  );

endinterface

// File: rtl/cursor_frame_sched_tick.sv
// Frame tick generator: free-running 0..FRAME_DIV-1 counter.
// Ports: clk, rst_n (sync, active-low), tick (one-cycle pulse).
module frame_tick_gen #(
  parameter int FRAME_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(FRAME_DIV);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(FRAME_DIV - 1));

  // Tick is registered off the wrap compare, so the first
  // tick lands exactly FRAME_DIV edges after reset release
  // and then repeats every FRAME_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_wrap)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/cursor_frame_sched.sv
// Cursor frame scheduler: per frame tick, scans NUM_CH ADC
// channels, delivers each sample, settles, then requests a
// UART packet. Ports: clk, rst_n (sync, active-low), bus
// (cursor_frame_sched_if.master: ADC, UART, control, status).
module cursor_frame_sched
  import boreal_sched_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int FRAME_DIV    = 1000,
  parameter int CONV_TIMEOUT = 255,
  parameter int SETTLE_CYC   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cursor_frame_sched_if.master bus
);

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic [CH_W-1:0]  r_idx;
  logic [CH_W-1:0]  w_idx_nxt;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] w_wcnt_nxt;
  logic [3:0]       r_scnt;
  logic [3:0]       w_scnt_nxt;
  logic [ADC_W-1:0] r_raw;
  logic             r_ovr;
  logic [CNT_W-1:0] r_tcnt;

  logic w_tick;
  logic w_run;
  logic w_adv;
  logic w_to;
  logic w_latch;
  logic w_last;

  frame_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  assign w_run  = bus.emergency_halt_n;
  assign w_last = (r_idx == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wcnt  <= '0;
      r_scnt  <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_scnt  <= w_scnt_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_idx_nxt  = r_idx;
    w_wcnt_nxt = r_wcnt;
    w_scnt_nxt = r_scnt;
    w_adv      = 1'b0;
    w_to       = 1'b0;
    w_latch    = 1'b0;
    if (!w_run) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_tick && bus.enable) begin
            w_next    = S_CONV;
            w_idx_nxt = '0;
          end
        end
        S_CONV: begin
          w_next     = S_WAIT;
          w_wcnt_nxt = '0;
        end
        S_WAIT: begin
          if (bus.adc_done) begin
            w_latch = 1'b1;
            w_next  = S_DELIVER;
          end else if (r_wcnt ==
                       CNT_W'(CONV_TIMEOUT - 1)) begin
            w_to  = 1'b1;
            w_adv = 1'b1;
          end else begin
            w_wcnt_nxt = r_wcnt + CNT_W'(1);
          end
        end
        S_DELIVER: begin
          w_adv = 1'b1;
        end
        S_SETTLE: begin
          if (r_scnt == 4'(SETTLE_CYC - 1))
            w_next = S_SEND;
          else
            w_scnt_nxt = r_scnt + 4'd1;
        end
        S_SEND: begin
          if (!bus.uart_busy)
            w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
      // Shared exit from WAIT (timeout) and DELIVER.
      if (w_adv) begin
        if (w_last) begin
          w_next     = S_SETTLE;
          w_scnt_nxt = '0;
        end else begin
          w_next    = S_CONV;
          w_idx_nxt = r_idx + CH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_raw <= '0;
    else if (w_latch)
      r_raw <= bus.adc_data_in;
  end

  // Set events take priority over clear_status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovr  <= 1'b0;
      r_tcnt <= '0;
    end else begin
      if (w_tick && (r_state != S_IDLE))
        r_ovr <= 1'b1;
      else if (bus.clear_status)
        r_ovr <= 1'b0;
      if (w_to)
        r_tcnt <= bus.clear_status ? CNT_W'(1)
                                   : sat_inc(r_tcnt);
      else if (bus.clear_status)
        r_tcnt <= '0;
    end
  end

  // Strobes are gated by halt so none escape in the cycle
  // the halt is asserted; the state fixes mutual exclusion.
  assign bus.adc_start      = w_run &&
                              (r_state == S_CONV);
  assign bus.adc_data_ready = w_run &&
                              (r_state == S_DELIVER);
  assign bus.send_packet_strobe = w_run &&
                                  (r_state == S_SEND) &&
                                  !bus.uart_busy;

  assign bus.raw_adc_out     = r_raw;
  assign bus.adc_channel_sel = r_idx;
  assign bus.frame_overrun   = r_ovr;
  assign bus.timeout_cnt     = r_tcnt;
  assign bus.sched_state     = r_state;

endmodule

// File: tb/tb_cursor_frame_sched.sv
// Directed bench for cursor_frame_sched with an ADC
// responder model and strobe monitor.
module tb_cursor_frame_sched;

  logic clk;
  logic rst_n;

  cursor_frame_sched_if sif ();

  cursor_frame_sched #(
    .NUM_CH      (8),
    .FRAME_DIV   (64),
    .CONV_TIMEOUT(6),
    .SETTLE_CYC  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;
  int rel;
  int dead   = -1;
  bit resp_en = 1'b1;

  int         as_cyc[$];
  int         sp_cyc[$];
  int         dr_cyc[$];
  int         dr_ch[$];
  logic [23:0] dr_dat[$];

  function automatic logic [23:0] mk(input int ch);
    return 24'hC0DE00 + 24'(ch * 17);
  endfunction

  function automatic int qat(input int q[$], input int i);
    if (i < q.size())
      return q[i];
    return -999;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    as_cyc.delete();
    sp_cyc.delete();
    dr_cyc.delete();
    dr_ch.delete();
    dr_dat.delete();
  endtask

  task automatic wait_sp(input int n, input int lim);
    int i;
    i = 0;
    while (sp_cyc.size() < n && i < lim) begin
      step(1);
      i++;
    end
    chk("sp_wait", sp_cyc.size(), n);
  endtask

  // Strobe monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (int'(sif.adc_start) + int'(sif.adc_data_ready) +
          int'(sif.send_packet_strobe) > 1)
        viol++;
      if (sif.adc_start)
        as_cyc.push_back(cyc);
      if (sif.send_packet_strobe)
        sp_cyc.push_back(cyc);
      if (sif.adc_data_ready) begin
        dr_cyc.push_back(cyc);
        dr_ch.push_back(int'(sif.adc_channel_sel));
        dr_dat.push_back(sif.raw_adc_out);
      end
    end
  end

  // ADC front end: done pulse 3 cycles after adc_start.
  initial begin
    int ch;
    sif.adc_done    = 1'b0;
    sif.adc_data_in = '0;
    forever begin
      @(negedge clk);
      if (sif.adc_start && resp_en &&
          int'(sif.adc_channel_sel) != dead) begin
        ch = int'(sif.adc_channel_sel);
        repeat (3) @(posedge clk);
        #1;
        sif.adc_done    = 1'b1;
        sif.adc_data_in = mk(ch);
        @(posedge clk);
        #1;
        sif.adc_done = 1'b0;
      end
    end
  end

  initial begin
    int i;
    int rel2;
    logic [23:0] raw;
    rst_n                = 1'b0;
    sif.enable           = 1'b0;
    sif.emergency_halt_n = 1'b1;
    sif.uart_busy        = 1'b0;
    sif.clear_status     = 1'b0;
    step(3);
    chk("rst_state", sif.sched_state, 0);
    chk("rst_raw", sif.raw_adc_out, 0);
    chk("rst_sel", sif.adc_channel_sel, 0);
    chk("rst_strb", {sif.adc_start, sif.adc_data_ready,
                     sif.send_packet_strobe}, 0);
    chk("rst_ovr", sif.frame_overrun, 0);
    chk("rst_tcnt", sif.timeout_cnt, 0);
    rst_n      = 1'b1;
    sif.enable = 1'b1;
    rel        = cyc;

    // Full frame, all channels answer.
    wait_sp(1, 200);
    chk("a_start", qat(as_cyc, 0) - rel, 65);
    chk("a_nrdy", dr_ch.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < dr_ch.size()) begin
        chk("a_ch", dr_ch[k], k);
        chk("a_dat", dr_dat[k], mk(k));
      end
    end
    chk("a_lat", qat(dr_cyc, 0) - qat(as_cyc, 0), 4);
    chk("a_send", qat(sp_cyc, 0) - qat(dr_cyc, 7), 5);

    // Channel 2 silent.
    clr();
    dead = 2;
    wait_sp(1, 200);
    chk("b_start", qat(as_cyc, 0) - rel, 129);
    chk("b_tcnt", sif.timeout_cnt, 1);
    chk("b_nstart", as_cyc.size(), 8);
    chk("b_nrdy", dr_ch.size(), 7);
    for (int k = 0; k < 7; k++)
      chk("b_ch", qat(dr_ch, k), (k < 2) ? k : k + 1);
    chk("b_ovr", sif.frame_overrun, 0);

    // UART busy across the next tick.
    dead = -1;
    clr();
    sif.uart_busy = 1'b1;
    while (cyc < rel + 260)
      step(1);
    chk("c_ovr", sif.frame_overrun, 1);
    chk("c_hold", sp_cyc.size(), 0);
    chk("c_state", sif.sched_state, 5);
    clr();
    sif.uart_busy = 1'b0;
    wait_sp(1, 5);
    chk("c_sp_cyc", qat(sp_cyc, 0) - rel, 260);
    clr();
    wait_sp(1, 150);
    chk("c_next", qat(as_cyc, 0) - rel, 321);
    chk("c_nrdy", dr_ch.size(), 8);
    sif.clear_status = 1'b1;
    step(1);
    sif.clear_status = 1'b0;
    chk("c_clr", sif.frame_overrun, 0);

    // Halt during WAIT of channel 4.
    clr();
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(sif.adc_start &&
                 sif.adc_channel_sel == 3'd4) && i < 200);
    chk("d_find", i < 200, 1);
    raw = sif.raw_adc_out;
    chk("d_raw3", raw, mk(3));
    step(1);
    chk("d_wait", sif.sched_state, 2);
    sif.emergency_halt_n = 1'b0;
    clr();
    step(1);
    sif.emergency_halt_n = 1'b1;
    chk("d_idle", sif.sched_state, 0);
    step(30);
    chk("d_quiet", as_cyc.size() + dr_ch.size() +
                   sp_cyc.size(), 0);
    chk("d_rawhold", sif.raw_adc_out, mk(3));
    wait_sp(1, 150);
    chk("d_restart", qat(as_cyc, 0) - rel, 449);
    chk("d_nrdy", dr_ch.size(), 8);

    // Timeout saturation and clear/timeout collision.
    sif.clear_status = 1'b1;
    step(1);
    sif.clear_status = 1'b0;
    chk("e_clr", sif.timeout_cnt, 0);
    resp_en = 1'b0;
    clr();
    wait_sp(38, 38 * 64 + 100);
    chk("e_sat", sif.timeout_cnt, 255);
    chk("e_ovr", sif.frame_overrun, 0);
    chk("e_nrdy", dr_ch.size(), 0);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!sif.adc_start && i < 200);
    chk("e_find", i < 200, 1);
    step(6);
    sif.clear_status = 1'b1;
    step(1);
    sif.clear_status = 1'b0;
    chk("e_coinc", sif.timeout_cnt, 1);

    // Reset mid-SETTLE.
    resp_en = 1'b1;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (sif.sched_state != 3'd4 && i < 300);
    chk("f_find", i < 300, 1);
    step(1);
    rst_n = 1'b0;
    step(1);
    chk("f_state", sif.sched_state, 0);
    chk("f_raw", sif.raw_adc_out, 0);
    chk("f_sel", sif.adc_channel_sel, 0);
    chk("f_strb", {sif.adc_start, sif.adc_data_ready,
                   sif.send_packet_strobe}, 0);
    chk("f_tcnt", sif.timeout_cnt, 0);
    chk("f_ovr", sif.frame_overrun, 0);
    rst_n = 1'b1;
    rel2  = cyc;
    clr();
    i = 0;
    while (as_cyc.size() == 0 && i < 200) begin
      step(1);
      i++;
    end
    chk("f_start", qat(as_cyc, 0) - rel2, 65);
    chk("f_nosp", sp_cyc.size(), 0);

    chk("excl", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cursor_frame_sched.md
CURSOR_FRAME_SCHED -- requirements
Module: cursor_frame_sched

Interface
REQ-001 Parameter NUM_CH, default 8, ADC channels scanned per frame (legal 1..8).
REQ-002 Parameter FRAME_DIV, default 1000, clock cycles per frame tick (legal >= 64).
REQ-003 Parameter CONV_TIMEOUT, default 255, max cycles waiting for adc_done (legal 1..255).
REQ-004 Parameter SETTLE_CYC, default 4, cycles between last channel delivery and packet send (legal 1..15).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 enable  in  1  level; 1 permits new frames to start.
REQ-008 emergency_halt_n  in  1  level; 0 aborts the current frame.
REQ-009 adc_start  out  1  one-cycle conversion request to the ADC front end.
REQ-010 adc_done  in  1  one-cycle conversion-complete pulse from the ADC front end.
REQ-011 adc_data_in  in  24  conversion result, valid when adc_done=1.
REQ-012 raw_adc_out  out  24  latched sample presented to the decoder core.
REQ-013 adc_channel_sel  out  3  channel index being converted or delivered.
REQ-014 adc_data_ready  out  1  one-cycle strobe qualifying raw_adc_out and adc_channel_sel.
REQ-015 uart_busy  in  1  cursor UART transmitter busy.
REQ-016 send_packet_strobe  out  1  one-cycle packet send request to the cursor UART.
REQ-017 clear_status  in  1  one-cycle pulse clearing frame_overrun and timeout_cnt.
REQ-018 frame_overrun  out  1  sticky flag: frame tick arrived while a frame was in progress.
REQ-019 timeout_cnt  out  8  saturating count of conversion timeouts.
REQ-020 sched_state  out  3  current FSM state encoding, for debug.

Function
REQ-021 The frame tick counter SHALL count 0..FRAME_DIV-1 and wrap, asserting tick for one cycle at FRAME_DIV-1.
REQ-022 FSM states: IDLE, CONV, WAIT, DELIVER, SETTLE, SEND.
REQ-023 IDLE->CONV on tick with enable=1 and emergency_halt_n=1; channel index := 0; adc_start=1 the cycle after tick.
REQ-024 CONV SHALL last one cycle (adc_start=1, adc_channel_sel=index), then go to WAIT with the wait counter cleared.
REQ-025 WAIT: on adc_done, latch adc_data_in into raw_adc_out and go to DELIVER; adc_data_ready=1 in the cycle after adc_done.
REQ-026 WAIT: after CONV_TIMEOUT cycles without adc_done, skip DELIVER, increment timeout_cnt (saturate at 255), and advance.
REQ-027 Advance: if index < NUM_CH-1, increment index and go to CONV; otherwise go to SETTLE.
REQ-028 adc_done outside WAIT SHALL be ignored; raw_adc_out holds its value except on a latch.
REQ-029 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to SEND.
REQ-030 SEND: while uart_busy=1, hold; on the first cycle with uart_busy=0, pulse send_packet_strobe for one cycle and return to IDLE.
REQ-031 A tick in any state other than IDLE SHALL set frame_overrun and be discarded; the frame in progress continues.
REQ-032 If clear_status and a set event coincide, the set SHALL win (flag=1, or count=1 for a timeout).
REQ-033 emergency_halt_n=0 in any state SHALL force IDLE on the next edge with no adc_start, adc_data_ready, or send_packet_strobe in that cycle or later until a new tick; the tick counter keeps running.
REQ-034 enable=0 SHALL NOT abort a frame in progress; it blocks only new frame starts.
REQ-035 At most one of adc_start, adc_data_ready, and send_packet_strobe SHALL be high in any cycle.

Reset
REQ-036 With rst_n=0 at an edge: state=IDLE, tick counter=0, index=0, raw_adc_out=0, adc_channel_sel=0, all strobes=0, frame_overrun=0, timeout_cnt=0.
REQ-037 Reset asserted mid-frame SHALL abandon the frame with no further strobes; the first tick occurs FRAME_DIV cycles after reset release.

Structure
REQ-038 Package boreal_sched_pkg SHALL hold the state encoding (IDLE=0, CONV=1, WAIT=2, DELIVER=3, SETTLE=4, SEND=5) and the ADC/channel width constants (24, 3).
REQ-039 The frame tick counter SHALL be a sub-module frame_tick_gen (parameter FRAME_DIV, output tick); the FSM stays in cursor_frame_sched.

Verification
REQ-040 NUM_CH=8, adc_done 3 cycles after each adc_start, uart_busy=0 -> 8 adc_data_ready pulses carrying channels 0..7 in order, then send_packet_strobe exactly SETTLE_CYC+1 cycles after the 8th DELIVER.
REQ-041 Channel 2 never answers -> timeout_cnt=1, no adc_data_ready for channel 2, channels 3..7 delivered, packet sent.
REQ-042 uart_busy held high past the next tick -> frame_overrun=1, single send_packet_strobe after uart_busy falls, next frame starts on the following tick.
REQ-043 emergency_halt_n pulsed low during WAIT of channel 4 -> IDLE next cycle, no further strobes that frame, normal frame on the next tick with halt released.
REQ-044 300 consecutive timeouts -> timeout_cnt=255; clear_status coincident with a timeout -> timeout_cnt=1.
REQ-045 rst_n low mid-SETTLE -> all outputs at reset values; first adc_start FRAME_DIV+1 cycles after release.
